// File: rtl/wb_fifo_uart.sv
// Wishbone classic UART with byte FIFOs on both directions and a runtime clocks-per-bit divider.
// Bus side effects land on the ack cycle; read data is only driven while ack is high.
//
// state     | meaning
// TX_IDLE   | line high, waiting for a byte in the TX FIFO
// TX_START  | driving the start bit (low) for DIV clocks
// TX_DATA   | shifting 8 data bits LSB first, DIV clocks each
// TX_STOP   | driving the stop bit (high) for DIV clocks
// RX_IDLE   | waiting for a falling edge on the synchronised line
// RX_START  | waiting half a bit to re-check the start bit
// RX_DATA   | sampling 8 data bits, one per DIV clocks
// RX_STOP   | sampling the stop bit
// RX_BREAK  | framing error seen, waiting for the line to return high

module wb_fifo_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module wb_fifo_uart #(
    parameter int CLK_FREQ_HZ = 24000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_o
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t   tx_st, tx_st_n;
    rx_state_t   rx_st, rx_st_n;
    logic [15:0] div_q, div_m1, half_m1;
    logic [1:0]  ctrl_q;
    logic        overrun_q, frame_q;
    logic        rx_s1, rx_sync, rx_prev;
    logic [15:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
    logic [7:0]  tx_sh, tx_sh_n, rx_sh, rx_sh_n;
    logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n;
    logic        tx_line_n, tx_pop, rx_push, ovr_set, frame_set;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_idle;
    logic [7:0]  tx_head, rx_head;
    logic        acc_wr, acc_rd, tx_wr, rx_rd, status_wr;
    logic [31:0] rdata;
    logic        unused_ok;

    assign acc_wr    = wb_ack_o & wb_we_i;
    assign acc_rd    = wb_ack_o & ~wb_we_i;
    assign tx_wr     = acc_wr & (wb_adr_i[3:2] == 2'd0);
    assign rx_rd     = acc_rd & (wb_adr_i[3:2] == 2'd0);
    assign status_wr = acc_wr & (wb_adr_i[3:2] == 2'd1);
    assign div_m1    = div_q - 16'd1;
    assign half_m1   = {1'b0, div_q[15:1]} - 16'd1;
    assign tx_idle   = tx_empty & (tx_st == TX_IDLE);
    assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:16]};

    wb_fifo_uart_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_wr), .din(wb_dat_i[7:0]),
        .pop(tx_pop), .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    wb_fifo_uart_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .din(rx_sh),
        .pop(rx_rd), .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        rdata = '0;
        case (wb_adr_i[3:2])
            2'd0: rdata[7:0] = rx_empty ? 8'd0 : rx_head;
            2'd1: rdata[5:0] = {tx_idle, frame_q, overrun_q, ~rx_empty, tx_empty, tx_full};
            2'd2: rdata[15:0] = div_q;
            default: rdata[1:0] = ctrl_q;
        endcase
    end

    assign wb_dat_o = wb_ack_o ? rdata : 32'd0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            div_q     <= DIV_RST;
            ctrl_q    <= 2'd0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            irq_o     <= 1'b0;
            rx_s1     <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
        end else begin
            wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
            if (acc_wr && wb_adr_i[3:2] == 2'd2)
                div_q <= (wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb_dat_i[15:0];
            if (acc_wr && wb_adr_i[3:2] == 2'd3)
                ctrl_q <= wb_dat_i[1:0];
            // a same-cycle set wins over a write-one-to-clear
            overrun_q <= ovr_set   | (overrun_q & ~(status_wr & wb_dat_i[3]));
            frame_q   <= frame_set | (frame_q   & ~(status_wr & wb_dat_i[4]));
            irq_o     <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle);
            rx_s1     <= uart_rx;
            rx_sync   <= rx_s1;
            rx_prev   <= rx_sync;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_st   <= TX_IDLE;
            tx_cnt  <= '0;
            tx_sh   <= '0;
            tx_bit  <= '0;
            uart_tx <= 1'b1;
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_sh   <= '0;
            rx_bit  <= '0;
        end else begin
            tx_st   <= tx_st_n;
            tx_cnt  <= tx_cnt_n;
            tx_sh   <= tx_sh_n;
            tx_bit  <= tx_bit_n;
            uart_tx <= tx_line_n;
            rx_st   <= rx_st_n;
            rx_cnt  <= rx_cnt_n;
            rx_sh   <= rx_sh_n;
            rx_bit  <= rx_bit_n;
        end
    end

    // uart_tx is registered alongside the state so each bit holds exactly DIV clocks
    always_comb begin
        tx_st_n   = tx_st;
        tx_cnt_n  = tx_cnt;
        tx_sh_n   = tx_sh;
        tx_bit_n  = tx_bit;
        tx_line_n = uart_tx;
        tx_pop    = 1'b0;
        case (tx_st)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_sh_n   = tx_head;
                    tx_cnt_n  = div_m1;
                    tx_st_n   = TX_START;
                    tx_line_n = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_st_n   = TX_DATA;
                    tx_cnt_n  = div_m1;
                    tx_bit_n  = 3'd0;
                    tx_line_n = tx_sh[0];
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            TX_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n = div_m1;
                    if (tx_bit == 3'd7) begin
                        tx_st_n   = TX_STOP;
                        tx_line_n = 1'b1;
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_sh_n   = {1'b0, tx_sh[7:1]};
                        tx_line_n = tx_sh[1];
                    end
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            default: begin
                if (tx_cnt == 16'd0) begin
                    if (!tx_empty) begin
                        tx_pop    = 1'b1;
                        tx_sh_n   = tx_head;
                        tx_cnt_n  = div_m1;
                        tx_st_n   = TX_START;
                        tx_line_n = 1'b0;
                    end else begin
                        tx_st_n   = TX_IDLE;
                        tx_line_n = 1'b1;
                    end
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
        endcase
    end

    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = rx_cnt;
        rx_sh_n   = rx_sh;
        rx_bit_n  = rx_bit;
        rx_push   = 1'b0;
        ovr_set   = 1'b0;
        frame_set = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_st_n  = RX_START;
                    rx_cnt_n = half_m1;
                end
            end
            RX_START: begin
                if (rx_cnt == 16'd0) begin
                    rx_st_n  = rx_sync ? RX_IDLE : RX_DATA;
                    rx_cnt_n = div_m1;
                    rx_bit_n = 3'd0;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            RX_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_sh_n  = {rx_sync, rx_sh[7:1]};
                    rx_cnt_n = div_m1;
                    if (rx_bit == 3'd7) rx_st_n = RX_STOP;
                    else rx_bit_n = rx_bit + 3'd1;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            RX_STOP: begin
                if (rx_cnt == 16'd0) begin
                    if (!rx_sync) begin
                        frame_set = 1'b1;
                        rx_st_n   = RX_BREAK;
                    end else begin
                        if (rx_full) ovr_set = 1'b1;
                        else rx_push = 1'b1;
                        rx_st_n = RX_IDLE;
                    end
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            RX_BREAK: if (rx_sync) rx_st_n = RX_IDLE;
            default: rx_st_n = RX_IDLE;
        endcase
    end
endmodule
